// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: streams consecutive ROM words into a small FIFO
// ahead of the core and flushes/restarts on a branch or jump redirect.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [31:0]                rom_addr_o,
  input  logic [31:0]                rom_data_i,
  output logic                       cpu_valid_o,
  input  logic                       cpu_ready_i,
  output logic [31:0]                cpu_inst_o,
  output logic [31:0]                cpu_pc_o,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] mem_pc   [DEPTH];
  logic [31:0] mem_inst [DEPTH];

  logic push, pop, not_empty;

  assign not_empty = (count_q != '0);

  // Push decision uses the registered count only, so a full queue takes a refill bubble.
  assign push = !rst && !redirect_i && (count_q < FullCount);
  assign pop  = not_empty && !redirect_i && cpu_ready_i;

  assign rom_ce_o    = push;
  assign rom_addr_o  = fetch_pc_q;
  assign cpu_valid_o = not_empty && !redirect_i;
  assign cpu_inst_o  = not_empty ? mem_inst[rd_ptr_q] : 32'h0;
  assign cpu_pc_o    = not_empty ? mem_pc[rd_ptr_q]   : 32'h0;
  assign occupancy_o = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
      mem_inst[wr_ptr_q] <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue against a combinational ROM model.
module tb_inst_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        cpu_valid_o;
  logic        cpu_ready_i;
  logic [31:0] cpu_inst_o;
  logic [31:0] cpu_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [2:0]  occupancy_o;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .cpu_valid_o   (cpu_valid_o),
    .cpu_ready_i   (cpu_ready_i),
    .cpu_inst_o    (cpu_inst_o),
    .cpu_pc_o      (cpu_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .occupancy_o   (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then settle before sampling.
  task automatic drive(input logic ready, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    cpu_ready_i   = ready;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ce"},   32'(rom_ce_o),    32'h0);
    check_eq({tag, "_addr"}, rom_addr_o,       32'h0);
    check_eq({tag, "_vld"},  32'(cpu_valid_o), 32'h0);
    check_eq({tag, "_inst"}, cpu_inst_o,       32'h0);
    check_eq({tag, "_pc"},   cpu_pc_o,         32'h0);
    check_eq({tag, "_occ"},  32'(occupancy_o), 32'h0);
  endtask

  logic [31:0] exp_pc;

  initial begin
    rst           = 1'b1;
    cpu_ready_i   = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #2;
    check_idle_outputs("rst");

    // Fill with the core stalled.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_ce",   32'(rom_ce_o),    32'h1);
    check_eq("rel_addr", rom_addr_o,       32'h0);
    check_eq("rel_vld",  32'(cpu_valid_o), 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    check_eq("fill1_vld",  32'(cpu_valid_o), 32'h1);
    check_eq("fill1_pc",   cpu_pc_o,         32'h0);
    check_eq("fill1_inst", cpu_inst_o,       rom_word(32'h0));
    check_eq("fill1_addr", rom_addr_o,       32'h4);
    drive(1'b0, 1'b0, 32'h0);
    check_eq("fill2_addr", rom_addr_o,       32'h8);
    drive(1'b0, 1'b0, 32'h0);
    check_eq("fill3_addr", rom_addr_o,       32'hC);
    drive(1'b0, 1'b0, 32'h0);
    check_eq("full_occ",  32'(occupancy_o), 32'h4);
    check_eq("full_ce",   32'(rom_ce_o),    32'h0);
    check_eq("full_addr", rom_addr_o,       32'h10);
    drive(1'b0, 1'b0, 32'h0);
    check_eq("hold_occ",  32'(occupancy_o), 32'h4);
    check_eq("hold_addr", rom_addr_o,       32'h10);
    check_eq("hold_pc",   cpu_pc_o,         32'h0);

    // Pop from full: no push that cycle, refill one cycle later.
    drive(1'b1, 1'b0, 32'h0);
    check_eq("fpop_vld", 32'(cpu_valid_o), 32'h1);
    check_eq("fpop_pc",  cpu_pc_o,         32'h0);
    check_eq("fpop_ce",  32'(rom_ce_o),    32'h0);
    exp_pc = 32'h4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        check_eq("refill_ce",   32'(rom_ce_o), 32'h1);
        check_eq("refill_addr", rom_addr_o,    32'h10);
      end
      check_eq("drain_vld",  32'(cpu_valid_o), 32'h1);
      check_eq("drain_pc",   cpu_pc_o,         exp_pc);
      check_eq("drain_inst", cpu_inst_o,       rom_word(exp_pc));
      check_eq("drain_occ",  32'(occupancy_o), 32'h3);
      exp_pc = exp_pc + 32'd4;
    end

    // Redirect with three entries queued; low address bits are dropped.
    drive(1'b1, 1'b1, 32'h0000_0103);
    check_eq("redir_vld", 32'(cpu_valid_o), 32'h0);
    check_eq("redir_ce",  32'(rom_ce_o),    32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("redir_occ",  32'(occupancy_o), 32'h0);
    check_eq("redir_addr", rom_addr_o,       32'h100);
    check_eq("redir_ce2",  32'(rom_ce_o),    32'h1);
    check_eq("redir_vld2", 32'(cpu_valid_o), 32'h0);
    check_eq("redir_pc0",  cpu_pc_o,         32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("tgt_vld",  32'(cpu_valid_o), 32'h1);
    check_eq("tgt_pc",   cpu_pc_o,         32'h100);
    check_eq("tgt_inst", cpu_inst_o,       rom_word(32'h100));
    drive(1'b1, 1'b0, 32'h0);
    check_eq("tgt_pc2",  cpu_pc_o,         32'h104);

    // Back-to-back redirects: the second target wins.
    drive(1'b1, 1'b1, 32'h0000_0200);
    drive(1'b1, 1'b1, 32'h0000_0305);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("b2b_addr", rom_addr_o,       32'h304);
    check_eq("b2b_vld",  32'(cpu_valid_o), 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("b2b_pc",   cpu_pc_o,         32'h304);

    // Address wrap at the top of the space.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr", rom_addr_o, 32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check_eq("wrap_vld", 32'(cpu_valid_o), 32'h1);
      check_eq("wrap_pc",  cpu_pc_o,         exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst         = 1'b0;
    cpu_ready_i = 1'b1;
    #1;
    check_eq("mrel_ce",   32'(rom_ce_o),    32'h1);
    check_eq("mrel_addr", rom_addr_o,       32'h0);
    check_eq("mrel_vld",  32'(cpu_valid_o), 32'h0);

    // Streaming with the core always ready.
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check_eq("strm_vld",  32'(cpu_valid_o), 32'h1);
      check_eq("strm_occ",  32'(occupancy_o), 32'h1);
      check_eq("strm_pc",   cpu_pc_o,         exp_pc);
      check_eq("strm_inst", cpu_inst_o,       rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
